ctrl_cnt_load_demux: RTL and testbench
======================================

# ctrl_cnt_load_demux

Input-side counterpart of the ReLU writeback mux counter: while operands are loaded into the SMAC datapath, this block counts accepted input words and generates the demux select and one-hot slot write enables that steer each word into one of up to four operand registers. It sits between the input stream source and the datapath operand registers, under control of the main FSM. It provides a valid/ready handshake and a done flag the FSM polls before starting computation.

## Interface
- DATA_W, 16, width of one input word / operand slot
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cnt_clear  in  1  synchronous abort: return to IDLE, counter to 1
- cnt_load  in  1  latch max_val into slot limit
- max_val  in  3  number of slots per load (1..4); 0 and 5..7 clamp to 4
- start  in  1  begin a load sequence
- in_valid  in  1  input word present
- in_data  in  DATA_W  input word
- in_ready  out  1  block accepts a word this cycle
- sel_demux  out  2  slot index of the next word to be accepted (counter − 1)
- slot_we  out  4  registered one-hot write enable, one cycle per accepted word
- slot_data  out  DATA_W  registered copy of accepted word, aligned with slot_we
- load_busy  out  1  high in LOAD
- load_done  out  1  high in DONE
- err_overrun  out  1  sticky overrun flag (see Configuration)

## Operation
- States: IDLE, LOAD, DONE. Counter cnt, 3 bits, range 1..limit; limit register 3 bits.
- Reset: state IDLE, cnt=1, limit=4, slot_we=0, slot_data=0, load_done=0, load_busy=0, in_ready=0, sel_demux=0, err_overrun=0.
- Control priority per cycle: cnt_clear > cnt_load > start > handshake.
- cnt_clear: any state → IDLE, cnt=1, slot_we=0 next cycle, err_overrun cleared; limit kept.
- cnt_load: accepted in IDLE and DONE only (limit ← clamp(max_val)); ignored in LOAD. State unchanged.
- start: IDLE or DONE → LOAD, cnt=1; ignored in LOAD. start with cnt_load in same cycle: only cnt_load acts.
- LOAD: in_ready=1. Accept = in_valid && in_ready. On accept: slot_data ← in_data, slot_we ← one-hot(cnt−1); if cnt==limit → DONE, cnt=1, else cnt+1.
- No accept in a cycle: slot_we=0 next cycle, cnt holds.
- DONE: in_ready=0, load_done=1, held until start or cnt_clear.
- in_ready, load_busy, load_done decode state combinationally; sel_demux = cnt−1 combinationally.
- Asynchronous reset mid-LOAD: immediate return to reset values; partial load discarded, no slot_we.

## Timing
- Accept at edge N → slot_we/slot_data valid for cycle after N only.
- Throughput: one word per cycle with in_valid held; limit=4 load takes 4 cycles from first accept.
- Last accept at edge N → load_done=1 from cycle after N, coincident with the last slot_we pulse.
- start at edge N → in_ready=1 from cycle after N.
- in_ready has no combinational path from in_valid.

## Configuration
- CTRL_LOAD_OVERRUN_EN defined: err_overrun sets (sticky) on any cycle where in_valid=1 and state is DONE; cleared only by rst_n or cnt_clear. IDLE is not flagged.
- Undefined: err_overrun is constant 0, no extra register.

## Test plan
- Reset, cnt_load max_val=3, start, in_valid held with data 0xA1,0xA2,0xA3 → slot_we 0001,0010,0100 on consecutive cycles with matching slot_data; load_done=1 with third pulse; in_ready=0 after.
- max_val=0 and max_val=6 → limit 4; four words produce slot_we 0001..1000, then DONE.
- limit=4, in_valid toggled 1,0,1,1,0,1 → four pulses only on accept cycles; sel_demux 0,1,1,2,3,3 → … holds during gaps.
- cnt_clear after 2 accepts of 4 → IDLE, no further slot_we, in_ready=0; start → sel_demux=0, new sequence from slot 0.
- cnt_load max_val=2 asserted in LOAD mid-sequence of limit 4 → ignored, four words loaded; in DONE cnt_load 2 then start → two-word load.
- With CTRL_LOAD_OVERRUN_EN: in_valid=1 in DONE → err_overrun=1, stays 1 across start, cleared by cnt_clear; without macro → err_overrun always 0.

Source files
------------

// File: rtl/ctrl_cnt_load_demux.sv
// ctrl_cnt_load_demux: counts accepted operand words during a load sequence and
// steers each one into one of up to four operand slots through a registered
// one-hot write enable. Optional macro CTRL_LOAD_OVERRUN_EN enables a sticky
// flag for words offered while the block sits in DONE.
module ctrl_cnt_load_demux #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cnt_clear,
  input  logic              cnt_load,
  input  logic [2:0]        max_val,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [1:0]        sel_demux,
  output logic [3:0]        slot_we,
  output logic [DATA_W-1:0] slot_data,
  output logic              load_busy,
  output logic              load_done,
  output logic              err_overrun
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned SLOTS   = 4;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_LOAD = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [SLOTS-1:0]   slot_we_q, slot_we_d;
  logic [DATA_W-1:0]  slot_data_q, slot_data_d;
  logic [CNT_W-1:0]   limit_clamped;
  logic               accept;

  // Status and steering outputs decode straight from registered state/counter
  assign in_ready  = (state_q == ST_LOAD);
  assign load_busy = (state_q == ST_LOAD);
  assign load_done = (state_q == ST_DONE);
  assign sel_demux = 2'(cnt_q - 3'd1);
  assign slot_we   = slot_we_q;
  assign slot_data = slot_data_q;

  assign accept        = in_valid && in_ready;
  assign limit_clamped = ((max_val == 3'd0) || (max_val > 3'd4)) ? 3'd4 : max_val;

  // State, counter, limit and slot write registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd1;
      limit_q     <= 3'd4;
      slot_we_q   <= '0;
      slot_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      slot_we_q   <= slot_we_d;
      slot_data_q <= slot_data_d;
    end
  end

  // Next-state logic: clear beats load beats start beats the handshake
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    limit_d     = limit_q;
    slot_we_d   = '0;
    slot_data_d = slot_data_q;
    if (cnt_clear) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cnt_load) begin
            limit_d = limit_clamped;
          end else if (start) begin
            state_d = ST_LOAD;
            cnt_d   = 3'd1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            slot_we_d   = 4'b0001 << sel_demux;
            slot_data_d = in_data;
            if (cnt_q == limit_q) begin
              state_d = ST_DONE;
              cnt_d   = 3'd1;
            end else begin
              cnt_d = 3'(cnt_q + 3'd1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd1;
        end
      endcase
    end
  end

`ifdef CTRL_LOAD_OVERRUN_EN
  logic err_q, err_d;

  assign err_overrun = err_q;

  // Sticky overrun: a word offered after the load already completed
  always_comb begin
    err_d = err_q;
    if (cnt_clear) begin
      err_d = 1'b0;
    end else if (in_valid && (state_q == ST_DONE)) begin
      err_d = 1'b1;
    end
  end

  // Overrun flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign err_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_cnt_load_demux.sv
// Directed bench for ctrl_cnt_load_demux with a word-count level reference model.
module tb_ctrl_cnt_load_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_clear = 1'b0;
  logic        cnt_load = 1'b0;
  logic [2:0]  max_val = 3'd0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_ready;
  logic [1:0]  sel_demux;
  logic [3:0]  slot_we;
  logic [15:0] slot_data;
  logic        load_busy;
  logic        load_done;
  logic        err_overrun;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  ctrl_cnt_load_demux #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_clear(cnt_clear), .cnt_load(cnt_load),
    .max_val(max_val), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sel_demux(sel_demux), .slot_we(slot_we),
    .slot_data(slot_data), .load_busy(load_busy), .load_done(load_done),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 loading, 2 complete; words_in = words taken this load
  int          m_mode;
  int          m_words;
  int          m_limit;
  logic [3:0]  m_we;
  logic [15:0] m_data;
  logic        m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_words = 0; m_limit = 4; m_we = 4'h0; m_data = 16'h0; m_err = 1'b0;
    end else begin
      m_we = 4'h0;
      if (cnt_clear) begin
        m_mode = 0; m_words = 0; m_err = 1'b0;
      end else begin
`ifdef CTRL_LOAD_OVERRUN_EN
        if (m_mode == 2 && in_valid) m_err = 1'b1;
`endif
        if (cnt_load && m_mode != 1) begin
          m_limit = (max_val >= 3'd1 && max_val <= 3'd4) ? int'(max_val) : 4;
        end else if (start && m_mode != 1) begin
          m_mode = 1; m_words = 0;
        end else if (m_mode == 1 && in_valid) begin
          m_we = 4'(1 << m_words);
          m_data = in_data;
          m_words++;
          if (m_words == m_limit) begin
            m_mode = 2; m_words = 0;
          end
        end
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle against the model, away from the rising edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("in_ready", int'(in_ready), int'(m_mode == 1));
      cmp("load_busy", int'(load_busy), int'(m_mode == 1));
      cmp("load_done", int'(load_done), int'(m_mode == 2));
      cmp("sel_demux", int'(sel_demux), m_words);
      cmp("slot_we", int'(slot_we), int'(m_we));
      if (m_we != 4'h0) cmp("slot_data", int'(slot_data), int'(m_data));
      cmp("err_overrun", int'(err_overrun), int'(m_err));
    end
  end

  // Drive one cycle of inputs, then settle just past the rising edge
  task automatic cyc(input bit clr, input bit ld, input logic [2:0] mv,
                     input bit st, input bit v, input logic [15:0] d);
    cnt_clear = clr; cnt_load = ld; max_val = mv; start = st; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0; cnt_load = 1'b0; start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic word(input logic [15:0] d);
    cyc(0, 0, 3'd0, 0, 1, d);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    cmp("rst_in_ready", int'(in_ready), 0);
    cmp("rst_sel", int'(sel_demux), 0);
    cmp("rst_we", int'(slot_we), 0);
    cmp("rst_data", int'(slot_data), 0);
    cmp("rst_done", int'(load_done), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Three-slot load
    cyc(0, 1, 3'd3, 0, 0, 16'h0);
    cyc(0, 0, 3'd0, 1, 0, 16'h0);
    cmp("t1_ready", int'(in_ready), 1);
    word(16'h00A1);
    cmp("t1_we0", int'(slot_we), 4'b0001);
    cmp("t1_d0", int'(slot_data), 16'h00A1);
    word(16'h00A2);
    cmp("t1_we1", int'(slot_we), 4'b0010);
    cmp("t1_d1", int'(slot_data), 16'h00A2);
    word(16'h00A3);
    cmp("t1_we2", int'(slot_we), 4'b0100);
    cmp("t1_d2", int'(slot_data), 16'h00A3);
    cmp("t1_done", int'(load_done), 1);
    cmp("t1_ready_off", int'(in_ready), 0);
    cyc(0, 0, 3'd0, 0, 0, 16'h0);
    cmp("t1_we_idle", int'(slot_we), 0);

    // Out-of-range limits clamp to four
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, (k == 0) ? 3'd0 : 3'd6, 0, 0, 16'h0);
      cyc(0, 0, 3'd0, 1, 0, 16'h0);
      for (int i = 0; i < 4; i++) word(16'hB000 + 16'(i));
      cmp("t2_we3", int'(slot_we), 4'b1000);
      cmp("t2_done", int'(load_done), 1);
    end

    // Gapped handshake, limit 4
    cyc(0, 0, 3'd0, 1, 0, 16'h0);
    word(16'hC0); cmp("t3_sel1", int'(sel_demux), 1);
    cyc(0, 0, 3'd0, 0, 0, 16'h0); cmp("t3_gap_we", int'(slot_we), 0);
    cmp("t3_sel_hold", int'(sel_demux), 1);
    word(16'hC1); cmp("t3_sel2", int'(sel_demux), 2);
    word(16'hC2); cmp("t3_sel3", int'(sel_demux), 3);
    cyc(0, 0, 3'd0, 0, 0, 16'h0); cmp("t3_sel3h", int'(sel_demux), 3);
    word(16'hC3); cmp("t3_we3", int'(slot_we), 4'b1000);
    cmp("t3_done", int'(load_done), 1);

    // Abort after two of four accepts
    cyc(0, 0, 3'd0, 1, 0, 16'h0);
    word(16'hD0); word(16'hD1);
    cyc(1, 0, 3'd0, 0, 1, 16'hDE);
    cmp("t4_clr_we", int'(slot_we), 0);
    cmp("t4_clr_ready", int'(in_ready), 0);
    cmp("t4_clr_busy", int'(load_busy), 0);
    word(16'hDF);
    cmp("t4_idle_we", int'(slot_we), 0);
    cyc(0, 0, 3'd0, 1, 0, 16'h0);
    cmp("t4_restart_sel", int'(sel_demux), 0);
    word(16'hD2); cmp("t4_we0", int'(slot_we), 4'b0001);
    word(16'hD3); word(16'hD4); word(16'hD5);
    cmp("t4_done", int'(load_done), 1);

    // cnt_load ignored mid-load, honoured in DONE
    cyc(0, 0, 3'd0, 1, 0, 16'h0);
    word(16'hE0);
    cyc(0, 1, 3'd2, 0, 0, 16'h0);
    word(16'hE1); word(16'hE2);
    cmp("t5_not_done", int'(load_done), 0);
    word(16'hE3);
    cmp("t5_four", int'(slot_we), 4'b1000);
    cyc(0, 1, 3'd2, 1, 0, 16'h0);
    cmp("t5_start_masked", int'(load_done), 1);
    cyc(0, 0, 3'd0, 1, 0, 16'h0);
    word(16'hE4); word(16'hE5);
    cmp("t5_two_we", int'(slot_we), 4'b0010);
    cmp("t5_two_done", int'(load_done), 1);

    // Overrun in DONE, persists across start, cleared by cnt_clear
    word(16'hF0);
`ifdef CTRL_LOAD_OVERRUN_EN
    cmp("t6_err_set", int'(err_overrun), 1);
`else
    cmp("t6_err_off", int'(err_overrun), 0);
`endif
    cyc(0, 0, 3'd0, 1, 0, 16'h0);
`ifdef CTRL_LOAD_OVERRUN_EN
    cmp("t6_err_sticky", int'(err_overrun), 1);
`endif
    cyc(1, 0, 3'd0, 0, 0, 16'h0);
    cmp("t6_err_clr", int'(err_overrun), 0);

    // Async reset mid-load
    cyc(0, 0, 3'd0, 1, 0, 16'h0);
    word(16'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("t7_rst_ready", int'(in_ready), 0);
    cmp("t7_rst_we", int'(slot_we), 0);
    cmp("t7_rst_sel", int'(sel_demux), 0);
    cmp("t7_rst_data", int'(slot_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 3'd0, 0, 0, 16'h0);
    cmp("t7_post_done", int'(load_done), 0);
    repeat (2) @(posedge clk);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
